game_ctrl: RTL and testbench

Frame-rate game sequencer for the HDMI dodge-and-collect game. It owns the game state machine (idle, play, dying, over), and decodes Enter and Space presses from the USB keycode. It schedules stone respawns into pseudo-random lanes, keeps the BCD score, high score and difficulty level, and drives `game_begin` and `game_over` to the player, stone and coin motion blocks. It sits between the keyboard/collision sources and the motion blocks, and feeds score and level to the text overlay.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_if.sv | 33 +++
 rtl/bcd_counter4.sv | 40 ++++
 rtl/game_ctrl.sv | 138 +++++++++++++
 tb/tb_game_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the frame-rate game sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam logic [7:0]  KEY_ENTER = 8'h28;
    localparam logic [7:0]  KEY_SPACE = 8'h2c;
    localparam int          NUM_LANES = 5;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [2:0] lane_of(input logic [15:0] lfsr);
        logic [2:0] raw;
        raw = lfsr[2:0];
        return (raw >= 3'(NUM_LANES)) ? raw - 3'(NUM_LANES) : raw;
    endfunction

endpackage

// File: rtl/game_if.sv
// Bundle between the game sequencer and its input sources / motion and overlay blocks.
interface game_if;
    import game_pkg::*;

    logic [7:0]  keycode;
    logic        hit_stone;
    logic        hit_coin;
    logic        stone_done;
    game_state_t state;
    logic        game_begin;
    logic        game_over;
    logic        spawn_stone;
    logic [2:0]  spawn_slot;
    logic [3:0]  fall_speed;
    logic [2:0]  level;
    logic [15:0] score;
    logic [15:0] high_score;

    // Sequencer side.
    modport master (
        input  keycode, hit_stone, hit_coin, stone_done,
        output state, game_begin, game_over, spawn_stone, spawn_slot,
               fall_speed, level, score, high_score
    );

    // Keyboard, collision and display side.
    modport slave (
        output keycode, hit_stone, hit_coin, stone_done,
        input  state, game_begin, game_over, spawn_stone, spawn_slot,
               fall_speed, level, score, high_score
    );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter: synchronous clear wins over increment, holds at 9999.
module bcd_counter4 (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_inc;
    logic        carry;

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch can be inferred.
        count_inc = count;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            count <= 16'h0000;
        end else if (clr) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'h9999)) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: state machine, key/edge decode, stone respawn lanes, score and level.
module game_ctrl
    import game_pkg::*;
#(
    parameter int          LEVEL_STEP  = 5,
    parameter int          MAX_LEVEL   = 7,
    parameter int          BASE_SPEED  = 2,
    parameter int          HOLD_FRAMES = 60,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic frame_clk,
    input logic Reset,
    game_if.master bus
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int STEP_W = $clog2(LEVEL_STEP + 1);

    game_state_t       state_q, state_d;
    logic [7:0]        key_prev;
    logic              coin_prev, done_prev;
    logic              enter_ev, space_ev, coin_ev, done_ev;
    logic [HOLD_W-1:0] hold_q;
    logic [STEP_W-1:0] step_q;
    logic [2:0]        level_q;
    logic [15:0]       score_q, high_q, lfsr_q;
    logic              spawn_q;
    logic [2:0]        slot_q;
    logic              hold_done;
    logic              begin_o, over_o;
    logic              score_clr, score_inc, spawn_req;

    assign enter_ev  = (bus.keycode == KEY_ENTER) && (key_prev != KEY_ENTER);
    assign space_ev  = (bus.keycode == KEY_SPACE) && (key_prev != KEY_SPACE);
    assign coin_ev   = bus.hit_coin && !coin_prev;
    assign done_ev   = bus.stone_done && !done_prev;
    assign hold_done = (hold_q == '0);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enter_ev)      state_d = PLAY;
            PLAY:    if (bus.hit_stone) state_d = DYING;
            DYING:   if (hold_done)     state_d = OVER;
            OVER:    if (space_ev)      state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // A collision in PLAY swallows any coin or stone_done edge of the same frame.
    always_comb begin
        begin_o   = 1'b0;
        over_o    = 1'b0;
        score_clr = 1'b0;
        score_inc = 1'b0;
        spawn_req = 1'b0;
        case (state_q)
            IDLE: begin
                score_clr = enter_ev;
                spawn_req = enter_ev;
            end
            PLAY: begin
                begin_o   = 1'b1;
                score_inc = coin_ev && !bus.hit_stone;
                spawn_req = done_ev && !bus.hit_stone;
            end
            DYING, OVER: over_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            key_prev  <= 8'h00;
            coin_prev <= 1'b0;
            done_prev <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            spawn_q   <= 1'b0;
            slot_q    <= 3'd0;
            hold_q    <= '0;
            step_q    <= '0;
            level_q   <= 3'd0;
            high_q    <= 16'h0000;
        end else begin
            key_prev  <= bus.keycode;
            coin_prev <= bus.hit_coin;
            done_prev <= bus.stone_done;
            lfsr_q    <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
            spawn_q   <= spawn_req;
            if (spawn_req) slot_q <= lane_of(lfsr_q);

            if (state_q == PLAY && bus.hit_stone) begin
                hold_q <= HOLD_W'(HOLD_FRAMES - 1);
            end else if (state_q == DYING && !hold_done) begin
                hold_q <= hold_q - 1'b1;
            end

            // The in-level counter keeps wrapping after the level saturates.
            if (score_clr) begin
                step_q  <= '0;
                level_q <= 3'd0;
            end else if (score_inc) begin
                if (step_q == STEP_W'(LEVEL_STEP - 1)) begin
                    step_q <= '0;
                    if (level_q != 3'(MAX_LEVEL)) level_q <= level_q + 3'd1;
                end else begin
                    step_q <= step_q + 1'b1;
                end
            end

            if (state_q == DYING && hold_done && score_q > high_q) high_q <= score_q;
        end
    end

    bcd_counter4 u_score (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clr       (score_clr),
        .inc       (score_inc),
        .count     (score_q)
    );

    assign bus.state       = state_q;
    assign bus.game_begin  = begin_o;
    assign bus.game_over   = over_o;
    assign bus.spawn_stone = spawn_q;
    assign bus.spawn_slot  = slot_q;
    assign bus.level       = level_q;
    assign bus.fall_speed  = 4'(BASE_SPEED) + {1'b0, level_q};
    assign bus.score       = score_q;
    assign bus.high_score  = high_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: vector table, directed corner cases, random run vs model.
module tb_game_ctrl;

    localparam int HOLD = 60;

    logic frame_clk = 1'b0;
    logic Reset;
    game_if gi ();

    game_ctrl #(
        .LEVEL_STEP  (5),
        .MAX_LEVEL   (7),
        .BASE_SPEED  (2),
        .HOLD_FRAMES (HOLD),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (gi)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: decimal counters and plain rules, states as 0..3.
    int          m_state, m_score, m_hi, m_level, m_coins, m_hold, m_slot;
    logic        m_spawn;
    logic [15:0] m_lfsr;
    logic [7:0]  m_kprev;
    logic        m_cprev, m_dprev;

    typedef struct {
        logic [7:0]  kc;
        logic        hs, hc, sd;
        logic [1:0]  st;
        logic        spawn;
        logic [15:0] score;
        logic [2:0]  lvl;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_hi = 0; m_level = 0; m_coins = 0; m_hold = 0;
        m_slot  = 0; m_spawn = 1'b0; m_lfsr = 16'hACE1;
        m_kprev = 8'h00; m_cprev = 1'b0; m_dprev = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] kc, input logic hs, hc, sd);
        logic enter, space, coin, done;
        int   lane;
        enter   = (kc == 8'h28) && (m_kprev != 8'h28);
        space   = (kc == 8'h2c) && (m_kprev != 8'h2c);
        coin    = hc && !m_cprev;
        done    = sd && !m_dprev;
        m_spawn = 1'b0;
        case (m_state)
            0: if (enter) begin
                m_state = 1; m_score = 0; m_level = 0; m_coins = 0; m_spawn = 1'b1;
            end
            1: if (hs) begin
                m_state = 2; m_hold = HOLD - 1;
            end else begin
                if (coin) begin
                    if (m_score < 9999) m_score++;
                    m_coins++;
                    if (m_coins == 5) begin
                        m_coins = 0;
                        if (m_level < 7) m_level++;
                    end
                end
                if (done) m_spawn = 1'b1;
            end
            2: if (m_hold == 0) begin
                m_state = 3;
                if (m_score > m_hi) m_hi = m_score;
            end else m_hold--;
            default: if (space) m_state = 0;
        endcase
        if (m_spawn) begin
            lane   = int'(m_lfsr % 16'd8);
            m_slot = (lane >= 5) ? lane - 5 : lane;
        end
        m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        m_kprev = kc; m_cprev = hc; m_dprev = sd;
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({gi.state, gi.game_begin, gi.game_over, gi.spawn_stone,
                    gi.spawn_stone ? gi.spawn_slot : 3'd0, gi.fall_speed, gi.level,
                    gi.score, gi.high_score});
    endfunction

    function automatic logic [63:0] model_vec();
        return 64'({2'(m_state), m_state == 1, m_state >= 2, m_spawn,
                    m_spawn ? 3'(m_slot) : 3'd0, 4'(2 + m_level), 3'(m_level),
                    to_bcd(m_score), to_bcd(m_hi)});
    endfunction

    // Called between edges: drive, let the DUT and model take the edge, compare at negedge.
    task automatic tick(input logic [7:0] kc, input logic hs, hc, sd);
        gi.keycode = kc; gi.hit_stone = hs; gi.hit_coin = hc; gi.stone_done = sd;
        @(posedge frame_clk);
        model_step(kc, hs, hc, sd);
        @(negedge frame_clk);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic coin_pulse();
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        gi.keycode = 8'h00; gi.hit_stone = 1'b0; gi.hit_coin = 1'b0; gi.stone_done = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", dut_vec(), 64'(2) << 35);
        check("reset_slot", 64'(gi.spawn_slot), 64'd0);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    initial begin
        int spawns, frames;
        logic [7:0] keys [5];
        keys[0] = 8'h00; keys[1] = 8'h00; keys[2] = 8'h28; keys[3] = 8'h2c; keys[4] = 8'h04;

        //          kc     hs    hc    sd    st     spawn score     lvl
        tbl.push_back('{8'h28, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 16'h0000, 3'd0});
        tbl.push_back('{8'h28, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 16'h0000, 3'd0});
        tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h0001, 3'd0});
        tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h0001, 3'd0});
        tbl.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 16'h0001, 3'd0});
        tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h0002, 3'd0});
        tbl.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'h0002, 3'd0});
        tbl.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0002, 3'd0});
        tbl.push_back('{8'h28, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 16'h0002, 3'd0});
        tbl.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0002, 3'd0});
        tbl.push_back('{8'h2c, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h0002, 3'd0});

        apply_reset();
        foreach (tbl[i]) begin
            tick(tbl[i].kc, tbl[i].hs, tbl[i].hc, tbl[i].sd);
            check($sformatf("vec%0d", i),
                  64'({gi.state, gi.spawn_stone, gi.score, gi.level}),
                  64'({tbl[i].st, tbl[i].spawn, tbl[i].score, tbl[i].lvl}));
        end

        // Enter held for 10 frames: one PLAY entry and a single spawn pulse.
        apply_reset();
        spawns = 0;
        for (int i = 0; i < 10; i++) begin
            tick(8'h28, 1'b0, 1'b0, 1'b0);
            if (i == 0) check("enter_to_play", 64'(gi.state), 64'd1);
            if (gi.spawn_stone) begin
                spawns++;
                check("slot_range", 64'(gi.spawn_slot <= 3'd4), 64'd1);
            end
        end
        check("spawn_count", 64'(spawns), 64'd1);

        // Five separate coins plus one held for four frames.
        for (int i = 0; i < 5; i++) coin_pulse();
        for (int i = 0; i < 4; i++) tick(8'h00, 1'b0, 1'b1, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0);
        check("score_6", 64'(gi.score), 64'h0006);
        check("level_1", 64'(gi.level), 64'd1);
        check("speed_3", 64'(gi.fall_speed), 64'd3);

        // Collision wins over a simultaneous coin edge.
        for (int i = 0; i < 6; i++) coin_pulse();
        tick(8'h00, 1'b1, 1'b1, 1'b0);
        check("die_state", 64'(gi.state), 64'd2);
        check("die_score", 64'(gi.score), 64'h0012);
        check("die_flags", 64'({gi.game_over, gi.game_begin}), 64'b10);

        // Space held while dying; OVER lands exactly HOLD frames after the collision edge.
        frames = 0;
        for (int i = 1; i <= 100; i++) begin
            tick(8'h2c, 1'b0, 1'b0, 1'b0);
            if (gi.state == 2'd3) begin
                frames = i;
                break;
            end
        end
        check("hold_frames", 64'(frames), 64'(HOLD));
        check("high_score", 64'(gi.high_score), 64'h0012);
        tick(8'h2c, 1'b0, 1'b0, 1'b0);
        check("space_held_over", 64'(gi.state), 64'd3);
        tick(8'h28, 1'b0, 1'b0, 1'b0);
        check("enter_in_over", 64'(gi.state), 64'd3);
        tick(8'h2c, 1'b0, 1'b0, 1'b0);
        check("space_to_idle", 64'(gi.state), 64'd0);
        check("score_kept", 64'(gi.score), 64'h0012);

        // Saturation of score and level.
        tick(8'h28, 1'b0, 1'b0, 1'b0);
        check("replay_clear", 64'({gi.state, gi.score}), 64'({2'd1, 16'h0000}));
        for (int i = 0; i < 9999; i++) coin_pulse();
        check("score_9999", 64'(gi.score), 64'h9999);
        coin_pulse();
        check("score_sat", 64'(gi.score), 64'h9999);
        check("level_sat", 64'({gi.level, gi.fall_speed}), 64'({3'd7, 4'd9}));
        check("high_in_play", 64'(gi.high_score), 64'h0012);

        // Asynchronous reset between edges, then the lane sequence restarts from the seed.
        #2;
        apply_reset();
        tick(8'h28, 1'b0, 1'b0, 1'b0);
        check("first_slot", 64'({gi.spawn_stone, gi.spawn_slot}), 64'({1'b1, 3'd1}));

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick(keys[$urandom_range(0, 4)], $urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
